// File: rtl/conv3x3_acc_pkg.sv
// Shared definitions for the 3x3 convolution accumulator.
//   BYTE_W : width of one window pixel / kernel tap
//   TAPS   : taps per 3x3 window
//   WIN_W  : packed window / kernel width (TAPS * BYTE_W)
//   PROD_W : unsigned pixel x signed tap product width
//   SUM_W  : width of the nine-product sum
//   CNT_W  : width of the job configuration counters
//   state_t: FSM state encoding
package conv3x3_acc_pkg;

  localparam int BYTE_W = 8;
  localparam int TAPS   = 9;
  localparam int WIN_W  = BYTE_W * TAPS;
  localparam int PROD_W = 17;
  localparam int SUM_W  = 21;
  localparam int CNT_W  = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/conv3x3_acc_dot.sv
// conv3x3_dot: two-stage registered 3x3 dot product.
//   Stage 1 registers nine products pixel(unsigned 8b) x tap(signed 8b).
//   Stage 2 registers their sign-extended sum. Both stages hold when en=0.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset (clears both stages)
//   en           : pipeline advance
//   pix          : window, pixel k = pix[8k+7:8k]
//   taps         : kernel, tap k = taps[8k+7:8k]
//   sum          : registered dot product, valid two enabled cycles after input
module conv3x3_dot
  import conv3x3_acc_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic [WIN_W-1:0]        pix,
  input  logic [WIN_W-1:0]        taps,
  output logic signed [SUM_W-1:0] sum
);

  logic signed [PROD_W-1:0] prod_d [TAPS];
  logic signed [PROD_W-1:0] prod_q [TAPS];
  logic signed [SUM_W-1:0]  sum_d;

  // Pixel is zero-extended and tap sign-extended to the product width so the
  // signed multiply covers 255 x -128 .. 255 x 127 without loss.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      prod_d[k] = $signed({{(PROD_W-BYTE_W){1'b0}}, pix[k*BYTE_W +: BYTE_W]})
                * $signed({{(PROD_W-BYTE_W){taps[k*BYTE_W+BYTE_W-1]}},
                           taps[k*BYTE_W +: BYTE_W]});
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < TAPS; k++) begin
      sum_d = sum_d + $signed({{(SUM_W-PROD_W){prod_q[k][PROD_W-1]}}, prod_q[k]});
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < TAPS; k++) prod_q[k] <= '0;
      sum <= '0;
    end else if (en) begin
      for (int k = 0; k < TAPS; k++) prod_q[k] <= prod_d[k];
      sum <= sum_d;
    end
  end

endmodule

// File: rtl/conv3x3_acc.sv
// conv3x3_acc: streams 3x3 windows, one per input channel, multiplies each by
// that channel's stored kernel and accumulates across channels to produce one
// signed result per output pixel.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset
//   start               : one-cycle pulse in IDLE, latches config and runs a job
//   no_of_input_layers  : channels per output pixel (1..MAX_CH)
//   out_pixel_count     : output pixels per job (>=1)
//   wgt_wr_en/addr/data : kernel write port, honoured only in IDLE
//   win_data/valid/rdy  : window input stream
//   acc_data/valid/rdy  : result output stream
//   busy                : job in progress
//   done                : pulses with the handshake of the job's last result
//   fsm_state           : current FSM state (observability)
// Handshake rule (both streams): a transfer happens on the rising edge where
// valid && rdy; valid, once raised, holds with stable data until that edge.
module conv3x3_acc
  import conv3x3_acc_pkg::*;
#(
  parameter int ACC_W  = 32,
  parameter int MAX_CH = 16
)(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [CNT_W-1:0]           no_of_input_layers,
  input  logic [CNT_W-1:0]           out_pixel_count,
  input  logic                       wgt_wr_en,
  input  logic [$clog2(MAX_CH)-1:0]  wgt_wr_addr,
  input  logic [WIN_W-1:0]           wgt_wr_data,
  input  logic [WIN_W-1:0]           win_data,
  input  logic                       win_valid,
  output logic                       win_rdy,
  output logic signed [ACC_W-1:0]    acc_data,
  output logic                       acc_valid,
  input  logic                       acc_rdy,
  output logic                       busy,
  output logic                       done,
  output state_t                     fsm_state
);

  localparam int AW = $clog2(MAX_CH);

  state_t state_q, state_d;

  logic [CNT_W-1:0] n_q;      // channels per pixel
  logic [CNT_W-1:0] cnt_q;    // pixels per job
  logic [CNT_W-1:0] ch_q;     // channel of the next window
  logic [CNT_W-1:0] pix_q;    // pixels whose windows are all accepted
  logic [CNT_W-1:0] res_q;    // results handed downstream

  logic [WIN_W-1:0] wgt_mem [MAX_CH];

  logic advance;
  logic accept;
  logic ch_last;
  logic out_hs;

  // Stage tags travelling beside the dot-product pipeline.
  logic v1, f1, l1;
  logic v2, f2, l2;

  logic signed [SUM_W-1:0] sum2;
  logic signed [ACC_W-1:0] sum_ext;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_next;

  // Everything moves together unless a result is parked waiting for acc_rdy.
  assign advance = !(acc_valid && !acc_rdy);
  assign accept  = win_valid && win_rdy;
  assign ch_last = (ch_q == n_q - 1'b1);
  assign out_hs  = acc_valid && acc_rdy;

  assign fsm_state = state_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    win_rdy = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        // pix_q < cnt_q is the same as "accepted windows < N * pixels"
        // because the channel counter wraps once per pixel.
        win_rdy = advance && (pix_q < cnt_q);
        if (out_hs && (res_q == cnt_q - 1'b1)) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------- job counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      n_q   <= '0;
      cnt_q <= '0;
      ch_q  <= '0;
      pix_q <= '0;
      res_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      n_q   <= no_of_input_layers;
      cnt_q <= out_pixel_count;
      ch_q  <= '0;
      pix_q <= '0;
      res_q <= '0;
    end else begin
      if (accept) begin
        if (ch_last) begin
          ch_q  <= '0;
          pix_q <= pix_q + 1'b1;
        end else begin
          ch_q  <= ch_q + 1'b1;
        end
      end
      if (out_hs) res_q <= res_q + 1'b1;
    end
  end

  // ----------------------------------------------------- kernel storage
  // Deliberately not reset: kernels survive a mid-job reset.
  always_ff @(posedge clk) begin
    if (wgt_wr_en && state_q == ST_IDLE) wgt_mem[wgt_wr_addr] <= wgt_wr_data;
  end

  // ------------------------------------------------- stages 1 and 2
  conv3x3_dot u_dot (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (advance),
    .pix     (win_data),
    .taps    (wgt_mem[ch_q[AW-1:0]]),
    .sum     (sum2)
  );

  // ------------------------------------------------------- stage 3
  assign sum_ext  = {{(ACC_W-SUM_W){sum2[SUM_W-1]}}, sum2};
  assign acc_next = f2 ? sum_ext : acc_q + sum_ext;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1        <= 1'b0;
      f1        <= 1'b0;
      l1        <= 1'b0;
      v2        <= 1'b0;
      f2        <= 1'b0;
      l2        <= 1'b0;
      acc_q     <= '0;
      acc_data  <= '0;
      acc_valid <= 1'b0;
    end else if (advance) begin
      v1 <= accept;
      f1 <= (ch_q == '0);
      l1 <= ch_last;
      v2 <= v1;
      f2 <= f1;
      l2 <= l1;
      if (v2) acc_q <= acc_next;
      // A handshake and a fresh result in the same cycle simply reload.
      acc_valid <= v2 && l2;
      if (v2 && l2) acc_data <= acc_next;
    end
  end

endmodule

// File: tb/tb_conv3x3_acc.sv
// Self-checking bench for conv3x3_acc: table of single-pixel jobs with
// hand-computed results, plus hand-written sequences for latency, tap
// ordering, ignored start/kernel writes, back-pressure, a random long job
// and reset mid-job.
module tb_conv3x3_acc;
  import conv3x3_acc_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] no_of_input_layers;
  logic [15:0] out_pixel_count;
  logic        wgt_wr_en;
  logic [3:0]  wgt_wr_addr;
  logic [71:0] wgt_wr_data;
  logic [71:0] win_data;
  logic        win_valid;
  logic        win_rdy;
  logic [31:0] acc_data;
  logic        acc_valid;
  logic        acc_rdy;
  logic        busy;
  logic        done;
  state_t      fsm_state;

  conv3x3_acc #(.ACC_W(32), .MAX_CH(16)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .start              (start),
    .no_of_input_layers (no_of_input_layers),
    .out_pixel_count    (out_pixel_count),
    .wgt_wr_en          (wgt_wr_en),
    .wgt_wr_addr        (wgt_wr_addr),
    .wgt_wr_data        (wgt_wr_data),
    .win_data           (win_data),
    .win_valid          (win_valid),
    .win_rdy            (win_rdy),
    .acc_data           (acc_data),
    .acc_valid          (acc_valid),
    .acc_rdy            (acc_rdy),
    .busy               (busy),
    .done               (done),
    .fsm_state          (fsm_state)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------ scoreboard
  logic [31:0] exp_q [$];
  logic [71:0] win_q [$];
  logic [71:0] kern [16];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt;
  bit done_bad;
  bit held_seen;
  bit stall_bad;
  logic [31:0] held_val;

  typedef struct {
    int n;
    int t0;
    int t1;
    int t2;   // tap for channels 2 and above
    int pix;
    int exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
               name, $signed(got), got, $signed(want), want);
    end
  endtask

  function automatic int dot9(input logic [71:0] w, input logic [71:0] t);
    int s = 0;
    logic [7:0] pb;
    logic signed [7:0] tb;
    for (int k = 0; k < 9; k++) begin
      pb = w[8*k +: 8];
      tb = t[8*k +: 8];
      s += int'(pb) * int'(tb);
    end
    return s;
  endfunction

  // --------------------------------------------------- driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
  endtask

  task automatic load_kernel(input int ch, input logic [71:0] data);
    wgt_wr_en   = 1'b1;
    wgt_wr_addr = 4'(ch);
    wgt_wr_data = data;
    kern[ch]    = data;
    step();
    wgt_wr_en   = 1'b0;
  endtask

  task automatic start_job(input int n, input int count);
    no_of_input_layers = 16'(n);
    out_pixel_count    = 16'(count);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Streams win_q into the DUT and checks every result handshake against
  // exp_q. acc_rdy is forced low for the first 'hold' cycles.
  task automatic run_stream(input int rdy_mode, input int hold, input int max_cyc);
    int cyc = 0;
    bit hs_in;
    bit hs_out;
    logic [31:0] want;
    while ((win_q.size() > 0 || exp_q.size() > 0) && cyc < max_cyc) begin
      if (cyc < hold)         acc_rdy = 1'b0;
      else if (rdy_mode == 1) acc_rdy = ($urandom_range(0, 7) != 0);
      else                    acc_rdy = 1'b1;
      win_valid = (win_q.size() > 0);
      win_data  = win_valid ? win_q[0] : '0;
      #1;
      hs_in  = win_valid && win_rdy;
      hs_out = acc_valid && acc_rdy;
      if (cyc < hold && acc_valid) begin
        if (!held_seen) begin
          held_seen = 1'b1;
          held_val  = acc_data;
        end else if (acc_data !== held_val || win_rdy) begin
          stall_bad = 1'b1;
        end
      end
      if (hs_out) begin
        if (exp_q.size() == 0) want = 32'hDEAD_BEEF;
        else                   want = exp_q.pop_front();
        check("acc_data", acc_data, want);
      end
      if (done) begin
        done_cnt++;
        if (!(hs_out && exp_q.size() == 0)) done_bad = 1'b1;
      end
      step();
      if (hs_in) void'(win_q.pop_front());
      cyc++;
    end
    win_valid = 1'b0;
    acc_rdy   = 1'b1;
    check("stream_drained", 32'(win_q.size() + exp_q.size()), 32'd0);
  endtask

  task automatic job_end_checks(input string tag);
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_timing"}, 32'(done_bad), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic clear_job_stats();
    done_cnt = 0;
    done_bad = 1'b0;
  endtask

  // ----------------------------------------------------------- test
  initial begin
    logic [71:0] w;
    logic [71:0] kw;
    int s;

    reset_n = 1'b0; start = 1'b0; no_of_input_layers = '0; out_pixel_count = '0;
    wgt_wr_en = 1'b0; wgt_wr_addr = '0; wgt_wr_data = '0;
    win_data = '0; win_valid = 1'b0; acc_rdy = 1'b0;
    for (int c = 0; c < 16; c++) kern[c] = '0;

    //            n   t0    t1    t2   pix  expected
    vecs[0] = '{  1,    1,    0,    0,  10,       90};
    vecs[1] = '{  3,    1,    2,   -1,   1,       18};
    vecs[2] = '{ 16, -128, -128, -128, 255, -4700160};
    vecs[3] = '{  1,  127,    0,    0, 255,   291465};
    vecs[4] = '{  2,   -1,    0,    0, 200,    -1800};
    vecs[5] = '{  1,    0,    0,    0, 255,        0};
    vecs[6] = '{  4,    5,   -3,    2,   7,      378};
    vecs[7] = '{ 16,  127,  127,  127, 255,  4663440};

    // Reset state
    do_reset();
    check("rst_acc_data", acc_data, 32'd0);
    check("rst_acc_valid", 32'(acc_valid), 32'd0);
    check("rst_win_rdy", 32'(win_rdy), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    reset_n = 1'b1;
    step();

    // Latency: accept -> acc_valid three edges later, done on handshake
    load_kernel(0, {9{8'sd1}});
    start_job(1, 1);
    check("lat_busy", 32'(busy), 32'd1);
    acc_rdy   = 1'b0;
    win_valid = 1'b1;
    win_data  = {9{8'd10}};
    #1;
    check("lat_win_rdy", 32'(win_rdy), 32'd1);
    step();
    win_valid = 1'b0;
    check("lat_valid_a1", 32'(acc_valid), 32'd0);
    step();
    check("lat_valid_a2", 32'(acc_valid), 32'd0);
    step();
    check("lat_valid_a3", 32'(acc_valid), 32'd1);
    check("lat_data", acc_data, 32'd90);
    check("lat_done_before_rdy", 32'(done), 32'd0);
    acc_rdy = 1'b1;
    #1;
    check("lat_done", 32'(done), 32'd1);
    step();
    check("lat_busy_after", 32'(busy), 32'd0);
    check("lat_valid_after", 32'(acc_valid), 32'd0);
    check("lat_done_after", 32'(done), 32'd0);

    // Table of single-pixel jobs with uniform taps/pixels per channel
    for (int v = 0; v < 8; v++) begin
      for (int c = 0; c < vecs[v].n; c++) begin
        s = (c == 0) ? vecs[v].t0 : (c == 1) ? vecs[v].t1 : vecs[v].t2;
        load_kernel(c, {9{8'(s)}});
      end
      start_job(vecs[v].n, 1);
      for (int c = 0; c < vecs[v].n; c++) win_q.push_back({9{8'(vecs[v].pix)}});
      exp_q.push_back(32'(vecs[v].exp));
      clear_job_stats();
      run_stream(0, 0, 200);
      job_end_checks($sformatf("vec%0d", v));
    end

    // Tap ordering: taps k-4; single-pixel probes hit taps 0 and 8
    for (int k = 0; k < 9; k++) kw[8*k +: 8] = 8'(k - 4);
    load_kernel(0, kw);
    start_job(1, 3);
    for (int k = 0; k < 9; k++) w[8*k +: 8] = 8'(k + 1);
    win_q.push_back(w);          exp_q.push_back(32'd60);
    w = '0; w[7:0] = 8'd50;
    win_q.push_back(w);          exp_q.push_back(-32'sd200);
    w = '0; w[71:64] = 8'd200;
    win_q.push_back(w);          exp_q.push_back(32'd800);
    clear_job_stats();
    run_stream(0, 0, 200);
    job_end_checks("order");

    // start and kernel writes during RUN are ignored
    load_kernel(0, {9{8'sd3}});
    load_kernel(1, {9{-8'sd2}});
    start_job(2, 1);
    start = 1'b1; no_of_input_layers = 16'd1; out_pixel_count = 16'd5;
    wgt_wr_en = 1'b1; wgt_wr_addr = 4'd0; wgt_wr_data = '0;
    step();
    start = 1'b0; wgt_wr_en = 1'b0;
    win_q.push_back({9{8'd4}});
    win_q.push_back({9{8'd4}});
    exp_q.push_back(32'd36);
    clear_job_stats();
    run_stream(0, 0, 200);
    job_end_checks("run_ignore");

    // Back-pressure: acc_rdy low 20 cycles, nothing lost
    load_kernel(0, {9{8'sd1}});
    start_job(1, 6);
    for (int i = 1; i <= 6; i++) begin
      win_q.push_back({9{8'(i)}});
      exp_q.push_back(32'(9 * i));
    end
    held_seen = 1'b0;
    stall_bad = 1'b0;
    clear_job_stats();
    run_stream(0, 20, 300);
    check("stall_seen", 32'(held_seen), 32'd1);
    check("stall_stable", 32'(stall_bad), 32'd0);
    job_end_checks("stall");

    // 13x13 pixels, 16 channels, random data, random acc_rdy
    for (int c = 0; c < 16; c++) begin
      for (int k = 0; k < 9; k++) kw[8*k +: 8] = 8'($urandom_range(0, 255));
      load_kernel(c, kw);
    end
    start_job(16, 169);
    for (int p = 0; p < 169; p++) begin
      s = 0;
      for (int c = 0; c < 16; c++) begin
        for (int k = 0; k < 9; k++) w[8*k +: 8] = 8'($urandom_range(0, 255));
        win_q.push_back(w);
        s += dot9(w, kern[c]);
      end
      exp_q.push_back(32'(s));
    end
    clear_job_stats();
    run_stream(1, 0, 20000);
    job_end_checks("random");

    // Reset mid-job, then a fresh job on the surviving kernels
    start_job(16, 4);
    acc_rdy   = 1'b1;
    win_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      win_data = {$urandom(), $urandom(), 8'($urandom())};
      step();
    end
    win_valid = 1'b0;
    reset_n   = 1'b0;
    step();
    check("midrst_acc_data", acc_data, 32'd0);
    check("midrst_acc_valid", 32'(acc_valid), 32'd0);
    check("midrst_win_rdy", 32'(win_rdy), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_state", 32'(fsm_state), 32'(ST_IDLE));
    reset_n = 1'b1;
    step();
    start_job(16, 2);
    for (int p = 0; p < 2; p++) begin
      s = 0;
      for (int c = 0; c < 16; c++) begin
        for (int k = 0; k < 9; k++) w[8*k +: 8] = 8'($urandom_range(0, 255));
        win_q.push_back(w);
        s += dot9(w, kern[c]);
      end
      exp_q.push_back(32'(s));
    end
    clear_job_stats();
    run_stream(0, 0, 500);
    job_end_checks("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv3x3_acc.md
CONV3X3_ACC -- requirements
Module: conv3x3_acc

Interface
REQ-001 Parameter ACC_W, default 32, accumulator/output width.
REQ-002 Parameter MAX_CH, default 16, kernel storage depth (channels).
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 reset_n  in  1  reset; synchronous, active-low.
REQ-005 start  in  1  one-cycle pulse; latches config, begins job.
REQ-006 no_of_input_layers  in  16  channels per output pixel (1..MAX_CH).
REQ-007 out_pixel_count  in  16  output pixels per job (>=1).
REQ-008 wgt_wr_en  in  1  kernel write strobe.
REQ-009 wgt_wr_addr  in  log2(MAX_CH)  kernel channel index.
REQ-010 wgt_wr_data  in  72  nine signed 8-bit taps; tap k = bits [8k+7:8k].
REQ-011 win_data  in  72  3x3 window from input_layer; pixel k (unsigned 8-bit) = bits [8k+7:8k].
REQ-012 win_valid  in  1  window valid.
REQ-013 win_rdy  out  1  window accepted when win_valid && win_rdy.
REQ-014 acc_data  out  ACC_W  signed accumulated convolution result.
REQ-015 acc_valid  out  1  result valid; held until acc_rdy.
REQ-016 acc_rdy  in  1  downstream ready.
REQ-017 busy  out  1  high in RUN.
REQ-018 done  out  1  one-cycle pulse when the last result is accepted.

Function
REQ-019 FSM states IDLE, RUN; IDLE->RUN on start; RUN->IDLE when the final pixel's result handshakes (done pulses same cycle).
REQ-020 start in RUN is ignored; wgt_wr_en SHALL be honoured only in IDLE.
REQ-021 Windows arrive channel-major per pixel: no_of_input_layers consecutive windows (ch 0..N-1) form one output pixel.
REQ-022 Channel counter selects kernel wgt[ch]; wraps to 0 after N-1 and increments the pixel counter.
REQ-023 Stage 1 (accept+1): nine products pixel(unsigned) x tap(signed), 17-bit signed each.
REQ-024 Stage 2 (accept+2): sum of nine products, sign-extended to 21 bits.
REQ-025 Stage 3 (accept+3): acc = sum if ch==0 else acc + sum, sign-extended to ACC_W, wrap-around on overflow (no saturation).
REQ-026 When stage 3 processes ch==N-1, acc_data/acc_valid SHALL assert at accept+3 for that window.
REQ-027 Pipeline advances when !(acc_valid && !acc_rdy); on stall all stages hold.
REQ-028 win_rdy = (state==RUN) && advance && (windows accepted < N*out_pixel_count).
REQ-029 Simultaneous acc handshake and new-result arrival in one cycle SHALL load the new result with no bubble.
REQ-030 N==1: every window produces one result; throughput one result/cycle with acc_rdy held high.

Reset
REQ-031 On reset_n low at a clock edge: state=IDLE, counters=0, all pipeline valids=0, acc_data=0, acc_valid=0, win_rdy=0, busy=0, done=0.
REQ-032 Reset mid-job SHALL discard in-flight data; kernel storage is not cleared.

Structure
REQ-033 Shared package holds window/tap byte width (8), taps per window (9), product width (17), sum width (21), FSM state encoding.
REQ-034 One sub-module conv3x3_dot: registered 9-tap multiply plus adder tree (stages 1-2), 2-cycle latency, with enable.
REQ-035 Kernel storage is a MAX_CH x 72 register array inside conv3x3_acc.

Verification
REQ-036 N=1, count=1, kernel all taps +1, window all pixels 10 -> acc_data=90, acc_valid 3 cycles after accept, done on handshake.
REQ-037 N=3, taps +1/+2/-1 per channel, pixels all 1 -> single result 9+18-9=18; no output after first two windows.
REQ-038 Taps all -128, pixels all 255, N=16 -> acc_data = -4700160, no overflow at ACC_W=32.
REQ-039 acc_rdy held low 20 cycles with result pending -> acc_data stable, win_rdy low, no window lost; release -> stream resumes.
REQ-040 Random acc_rdy (1 in 8) over 13x13 pixels, N=16 -> 169 results match reference model, done once, then busy=0.
REQ-041 reset_n low mid-job -> next cycle all outputs zero, IDLE; new start completes correctly using kernels loaded before reset.
